// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared state encoding and defaults for seq_multiplier
//
// Purpose: state encoding for the seq_multiplier controller and the default
//          operand width. Imported by seq_multiplier.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_ripple_adder.sv
// rtl/seq_multiplier_ripple_adder.sv - WIDTH-bit ripple add/subtract chain of full adders
//
// full_adder ports:
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
// ripple_adder ports:
//   a, b     : WIDTH-bit operands
//   sub      : 1 computes a - b (b inverted, carry-in 1), 0 computes a + b
//   sum      : WIDTH-bit result
//   cout     : carry out of the top cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_x;

  // Two's complement subtract: invert b and inject the +1 as carry-in.
  assign b_x      = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a  (a[i]),
      .b  (b_x[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-add WIDTH x WIDTH multiplier
//
// Purpose: computes a 2*WIDTH-bit product over WIDTH RUN cycles using one
//          WIDTH-bit ripple adder. Optional signed mode under the macro
//          SEQ_MULT_SIGNED_EN.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   start       : request a multiply, accepted in IDLE or DONE
//   A, B        : multiplicand / multiplier, sampled on the accepting edge
//   signed_mode : (SEQ_MULT_SIGNED_EN only) treat A, B as two's complement
//   busy        : high while in RUN
//   done        : one-cycle pulse, P valid
//   P           : product, driven from the accumulator
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_n;
  logic   accept;
  logic   busy_n, done_n;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               last;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             sub;
  logic             top;

  assign last = (cnt == CW'(WIDTH - 1));

  // Multiplier bit 0 selects whether this step adds the multiplicand.
  assign addend = acc[0] ? mcand : '0;

`ifdef SEQ_MULT_SIGNED_EN
  logic sgn;

  // The multiplier's MSB carries negative weight, so the last step subtracts.
  assign sub = acc[0] & sgn & last;
  // Sign of the exact (WIDTH+1)-bit sum of sign-extended operands; with no
  // add this reduces to the current partial-product sign (arithmetic shift).
  assign top = sgn ? (acc[2*WIDTH-1] ^ addend[WIDTH-1] ^ sub ^ cout) : cout;
`else
  assign sub = 1'b0;
  assign top = cout;
`endif

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .sub  (sub),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sgn   <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= A;
      acc   <= {{WIDTH{1'b0}}, B};
      cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sgn   <= signed_mode;
`endif
    end else if (state == RUN) begin
      acc <= {top, sum, acc[WIDTH-1:1]};
      // Hold at WIDTH-1 so the counter never wraps within an operation.
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  assign P = acc;

endmodule
